// File: rtl/soma_pkg.sv
// soma_pkg: op encodings and helpers shared by the soma pipeline
package soma_pkg;
  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_ACC  = 2'b10,
    OP_LOAD = 2'b11
  } op_t;
  function automatic logic uses_acc(input op_t o);
    return o == OP_ACC || o == OP_LOAD;
  endfunction
endpackage

// File: rtl/soma_seg.sv
// soma_seg: one registered carry-chain segment with stall enable
module soma_seg #(
  parameter int SW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [SW-1:0] x,
  input  logic [SW-1:0] y,
  input  logic          cin,
  output logic [SW-1:0] s,
  output logic          cout
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {cout, s} <= '0;
    else if (en) {cout, s} <= {1'b0, x} + {1'b0, y} + (SW+1)'(cin);
endmodule

// File: rtl/soma_pipe.sv
// soma_pipe: segmented-carry pipelined add/sub/accumulate unit with valid/ready handshake
module soma_pipe
  import soma_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [WIDTH-1:0] acc
);
  localparam int SW = WIDTH / STAGES;
  op_t opi;
  logic en, hazard, ci, vi;
  logic [WIDTH-1:0] xi, yi;
  logic [STAGES-1:0] busy;
  assign opi      = op_t'(op);
  assign en       = !(out_valid & !out_ready);
  assign hazard   = (opi == OP_ACC) & |busy;
  assign in_ready = rst_n & en & !hazard;
  assign vi       = in_valid & in_ready;
  assign ci       = opi == OP_SUB;
  assign xi       = opi == OP_ACC ? acc : a;
  assign yi       = opi == OP_ADD ? b : opi == OP_SUB ? ~b : opi == OP_ACC ? a : '0;
  // each stage consumes the low segment of the operands it receives and forwards the rest
  for (genvar k = 0; k < STAGES; k++) begin : g
    localparam int RW = WIDTH - k * SW;
    logic [RW-1:0] xk, yk;
    logic [SW-1:0] sk;
    logic [(k+1)*SW-1:0] s_q;
    logic ck, vk, c_q, v_q;
    op_t ok, o_q;
    if (k == 0) begin : f
      assign xk  = xi;
      assign yk  = yi;
      assign ck  = ci;
      assign vk  = vi;
      assign ok  = opi;
      assign s_q = sk;
    end else begin : m
      logic [k*SW-1:0] p_q;
      assign xk  = g[k-1].r.x_q;
      assign yk  = g[k-1].r.y_q;
      assign ck  = g[k-1].c_q;
      assign vk  = g[k-1].v_q;
      assign ok  = g[k-1].o_q;
      assign s_q = {sk, p_q};
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) p_q <= '0;
        else if (en) p_q <= g[k-1].s_q;
    end
    if (k < STAGES - 1) begin : r
      logic [RW-SW-1:0] x_q, y_q;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          x_q <= '0;
          y_q <= '0;
        end else if (en) begin
          x_q <= xk[RW-1:SW];
          y_q <= yk[RW-1:SW];
        end
    end else begin : l
      logic xm, ym;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          xm <= 1'b0;
          ym <= 1'b0;
        end else if (en) begin
          xm <= xk[RW-1];
          ym <= yk[RW-1];
        end
    end
    soma_seg #(.SW(SW)) u_seg (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en),
      .x    (xk[SW-1:0]),
      .y    (yk[SW-1:0]),
      .cin  (ck),
      .s    (sk),
      .cout (c_q)
    );
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        v_q <= 1'b0;
        o_q <= OP_ADD;
      end else if (en) begin
        v_q <= vk;
        o_q <= ok;
      end
    assign busy[k] = v_q & uses_acc(o_q);
  end
  assign out_valid = g[STAGES-1].v_q;
  assign sum       = g[STAGES-1].s_q;
  assign cout      = g[STAGES-1].c_q;
  // carry into the MSB differs from carry out exactly on signed overflow
  assign ovf       = cout ^ g[STAGES-1].l.xm ^ g[STAGES-1].l.ym ^ sum[WIDTH-1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acc <= '0;
    else if (out_valid & out_ready & uses_acc(g[STAGES-1].o_q)) acc <= sum;
endmodule

// File: tb/tb_soma_pipe.sv
// tb_soma_pipe: directed and randomized checks of soma_pipe against a queue-based reference model
module tb_soma_pipe;
  localparam int WIDTH  = 64;
  localparam int STAGES = 2;
  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, ACC = 2'b10, LOAD = 2'b11;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, out_valid, out_ready, cout, ovf;
  logic [1:0] op;
  logic [WIDTH-1:0] a, b, sum, acc;
  typedef struct {
    logic [63:0] s;
    logic        c;
    logic        v;
    logic        ac;
    int          age;
  } ent_t;
  ent_t q[$];
  logic [63:0] macc = '0;
  logic last_acc;
  int n_pass = 0, n_fail = 0, n_tot = 0, last_wait = 0;

  soma_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .ovf(ovf), .acc(acc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic ent_t model(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y,
                                 input logic [63:0] m);
    ent_t e;
    logic [64:0] r;
    e.age = 1;
    e.ac  = (o == ACC) || (o == LOAD);
    case (o)
      ADD: begin
        r   = {1'b0, x} + {1'b0, y};
        e.c = r[64];
        e.v = (x[63] == y[63]) && (r[63] != x[63]);
      end
      SUB: begin
        r   = {1'b0, x} - {1'b0, y};
        e.c = ~r[64];
        e.v = (x[63] != y[63]) && (r[63] != x[63]);
      end
      ACC: begin
        r   = {1'b0, m} + {1'b0, x};
        e.c = r[64];
        e.v = (m[63] == x[63]) && (r[63] != m[63]);
      end
      default: begin
        r   = {1'b0, x};
        e.c = 1'b0;
        e.v = 1'b0;
      end
    endcase
    e.s = r[63:0];
    return e;
  endfunction

  function automatic logic acc_busy();
    foreach (q[i]) if (q[i].ac) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step(input logic iv, input logic [1:0] o, input logic [63:0] aa,
                      input logic [63:0] bb, input logic ordy);
    logic ev, stall, eir, xfer;
    ent_t e;
    @(negedge clk);
    in_valid = iv; op = o; a = aa; b = bb; out_ready = ordy;
    #1;
    ev = q.size() > 0 && q[0].age >= STAGES;
    chk("out_valid", out_valid, ev);
    if (ev) begin
      chk("sum", sum, q[0].s);
      chk("cout", cout, q[0].c);
      chk("ovf", ovf, q[0].v);
    end
    chk("acc", acc, macc);
    stall = ev & !ordy;
    eir = !stall && !(o == ACC && acc_busy());
    chk("in_ready", in_ready, eir);
    last_acc = iv & eir;
    xfer = ev & ordy;
    e = model(o, aa, bb, macc);
    @(posedge clk);
    if (xfer) begin
      if (q[0].ac) macc = q[0].s;
      void'(q.pop_front());
    end
    if (!stall) for (int i = 0; i < q.size(); i++) q[i].age = q[i].age + 1;
    if (last_acc) q.push_back(e);
  endtask

  task automatic send(input logic [1:0] o, input logic [63:0] aa, input logic [63:0] bb,
                      input logic ordy);
    int n = 0;
    do begin
      step(1'b1, o, aa, bb, ordy);
      n++;
    end while (!last_acc && n < 50);
    chk("send_accept", last_acc, 1'b1);
    last_wait = n - 1;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 40) begin
      step(1'b0, ADD, '0, '0, 1'b1);
      n++;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  function automatic logic [63:0] pick();
    case ($urandom % 4)
      0: return 64'h0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = ADD; a = '0; b = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_sum", sum, 64'h0);
    chk("rst_cout", cout, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_acc", acc, 64'h0);
    chk("rst_in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_in_ready", in_ready, 1'b1);

    step(1'b1, ADD, 64'd4, 64'd6, 1'b1);
    step(1'b0, ADD, '0, '0, 1'b1);
    #2;
    chk("add_valid", out_valid, 1'b1);
    chk("add_sum", sum, 64'd10);
    chk("add_cout", cout, 1'b0);
    chk("add_ovf", ovf, 1'b0);
    drain();

    step(1'b1, SUB, 64'd13, 64'd50, 1'b1);
    step(1'b0, ADD, '0, '0, 1'b1);
    #2;
    chk("sub_sum", sum, 64'hFFFF_FFFF_FFFF_FFDB);
    chk("sub_cout", cout, 1'b0);
    chk("sub_ovf", ovf, 1'b0);
    step(1'b1, ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
    step(1'b1, ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
    #2;
    chk("wrap_sum", sum, 64'h0);
    chk("wrap_cout", cout, 1'b1);
    step(1'b0, ADD, '0, '0, 1'b1);
    #2;
    chk("ovf_flag", ovf, 1'b1);
    chk("ovf_sum", sum, 64'h8000_0000_0000_0000);
    drain();

    step(1'b1, ADD, 64'd10, 64'd20, 1'b0);
    step(1'b1, ADD, 64'd30, 64'd40, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, ADD, 64'd50, 64'd60, 1'b0);
      #2;
      chk("stall_in_ready", in_ready, 1'b0);
      chk("stall_hold_sum", sum, 64'd30);
      chk("stall_hold_valid", out_valid, 1'b1);
    end
    send(ADD, 64'd50, 64'd60, 1'b1);
    drain();

    send(LOAD, 64'd49, 64'd0, 1'b1);
    send(ACC, 64'd74, 64'd0, 1'b1);
    chk("acc74_waited", last_wait > 0, 1'b1);
    send(ACC, 64'd7, 64'd0, 1'b1);
    chk("acc7_waited", last_wait > 0, 1'b1);
    drain();
    #2;
    chk("final_acc", acc, 64'd130);

    send(ADD, 64'd1, 64'd1, 1'b0);
    send(ADD, 64'd2, 64'd2, 1'b0);
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b0);
    chk("midrst_acc", acc, 64'h0);
    q.delete();
    macc = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_release_ready", in_ready, 1'b1);
    repeat (4) step(1'b0, ADD, '0, '0, 1'b1);
    send(ADD, 64'd1, 64'd2, 1'b1);
    step(1'b0, ADD, '0, '0, 1'b1);
    #2;
    chk("post_rst_sum", sum, 64'd3);
    drain();

    for (int i = 0; i < 400; i++)
      step(($urandom % 4) != 0, 2'($urandom % 4), pick(), pick(), ($urandom % 3) != 0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/soma_pipe.md
SOMA_PIPE -- requirements
Module: soma_pipe

Interface
REQ-001 Parameter WIDTH, default 64: operand/result width in bits, SHALL be >= 2.
REQ-002 Parameter STAGES, default 2: pipeline depth and carry-chain segment count, SHALL be >= 1 and divide WIDTH exactly.
REQ-003 Port clk, input, 1: sole clock; all state updates on posedge.
REQ-004 Port rst_n, input, 1: asynchronous reset, active-low.
REQ-005 Port in_valid, input, 1: operands and op presented.
REQ-006 Port in_ready, output, 1: block accepts; transfer when in_valid & in_ready at posedge.
REQ-007 Port op, input, 2: 00 add a+b; 01 sub a-b; 10 accumulate acc+a; 11 load acc=a.
REQ-008 Ports a, b, input, WIDTH each: operands; b ignored for op 10/11.
REQ-009 Port out_valid, output, 1: result valid.
REQ-010 Port out_ready, input, 1: consumer accepts; transfer when out_valid & out_ready.
REQ-011 Port sum, output, WIDTH: result modulo 2^WIDTH.
REQ-012 Port cout, output, 1: carry out of MSB (sub: 1 = no borrow; op 11: 0).
REQ-013 Port ovf, output, 1: two's-complement signed overflow (op 11: 0).
REQ-014 Port acc, output, WIDTH: current accumulator register.

Function
REQ-015 Add/sub SHALL be computed as a + (b XOR {WIDTH{sub}}) + sub, split into STAGES segments of WIDTH/STAGES bits, one segment per stage, carry registered between stages.
REQ-016 Latency SHALL be exactly STAGES cycles from accepted input to out_valid when not stalled; throughput one op per cycle.
REQ-017 Stall rule: pipeline SHALL hold all stages when out_valid & !out_ready; in_ready = !(out_valid & !out_ready) & !hazard.
REQ-018 Results SHALL leave in acceptance order; no op dropped or duplicated under any stall pattern.
REQ-019 out_valid, sum, cout, ovf SHALL stay stable while out_valid & !out_ready.
REQ-020 Op 10 SHALL read acc at the first stage; hazard = (op==10) & any op 10/11 in flight; while hazard, in_ready SHALL be 0.
REQ-021 Op 11 SHALL never raise hazard; op 00/01 never interact with acc.
REQ-022 acc SHALL update to sum when an op 10/11 result transfers out (out_valid & out_ready), not earlier.
REQ-023 Wrap-around: sum SHALL wrap modulo 2^WIDTH with cout/ovf reporting; no saturation.
REQ-024 Bubbles (no valid input) SHALL propagate as out_valid=0 without altering acc.

Reset
REQ-025 On rst_n low, asynchronously: all stage valid bits 0, out_valid 0, sum 0, cout 0, ovf 0, acc 0.
REQ-026 in_ready SHALL be 0 while rst_n low and 1 in the first cycle after release.
REQ-027 Reset mid-operation SHALL discard all in-flight ops; no result emitted after release for pre-reset inputs.

Structure
REQ-028 Op encodings (OP_ADD, OP_SUB, OP_ACC, OP_LOAD) SHALL live in shared package soma_pkg.
REQ-029 One sub-module soma_seg SHALL implement one registered segment (WIDTH/STAGES-bit add, carry in/out, stall enable), instantiated STAGES times via generate.
REQ-030 STAGES=1 SHALL degenerate to a single registered adder with handshake.

Verification (WIDTH=64, STAGES=2)
REQ-031 Add 4+6, out_ready=1 -> two cycles later sum=10, cout=0, ovf=0.
REQ-032 Sub 13-50 -> sum=0xFFFFFFFFFFFFFFDB, cout=0, ovf=0; 0xFFFFFFFFFFFFFFFF+1 -> sum=0, cout=1; 0x7FFFFFFFFFFFFFFF+1 -> ovf=1.
REQ-033 Three back-to-back adds, out_ready low 5 cycles -> in_ready low during stall, all three results delivered in order, values unchanged while held.
REQ-034 Load 49, acc 74, acc 7 back-to-back -> outputs 49, 123, 130; in_ready low while each op 10 waits; final acc=130.
REQ-035 Two ops in flight, rst_n low one cycle -> out_valid stays 0 afterward, acc=0, next add 1+2 yields 3.
